video_arith_arbiter: RTL and testbench
======================================

Name: video_arith_arbiter

Overview:
- Shares one sys_umul #(12,12) and one sys_udiv #(24,12) between NREQ requesters in the CLK_VIDEO domain.
- Typical requesters: the crop aspect-ratio calculation and the integer-scale calculation in the video scaler path. Each currently instantiates its own multiplier and divider.
- Requesters use a four-phase req/done handshake. The arbiter picks a winner round-robin, sequences the engine start and run, and returns the result.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ZDIV_RES, 24'hFFFFFF, result returned for division by zero.

Ports:
- CLK_VIDEO  in  1  video clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- op  in  NREQ  per-requester operation: 0 = multiply a[11:0]*b, 1 = divide a/b.
- arg_a  in  NREQ*24  per-requester operand A, slice i = [24*i+23:24*i].
- arg_b  in  NREQ*12  per-requester operand B, slice i = [12*i+11:12*i].
- done  out  NREQ  per-requester completion level.
- res  out  24  result of the most recent completed operation.
- grant  out  NREQ  one-hot owner of the engine; zero when idle.
- busy  out  1  engine owned (state != IDLE).

Behaviour:
- Reset values: done=0, grant=0, busy=0, res=0, state=IDLE, RR pointer=0. Reset takes effect on the next edge from any state.
- Reset mid-operation abandons the in-flight result. No done is ever issued for it. The engine run is still honoured, because IDLE does not issue while mul_run or div_run is high.
- Handshake:
  - Requester holds req[i]=1 with op[i], arg_a[i] and arg_b[i] stable until done[i]=1.
  - done[i] stays 1 until req[i]=0.
  - res is valid whenever done[i]=1 and holds its value until the next completion.
  - Dropping req[i] before done[i] is illegal. The operation completes anyway and done[i] pulses for one cycle.
- States:
  - IDLE:
    - if any req and ~mul_run & ~div_run: pick winner g, latch op/a/b, set grant.
    - if op=1 and b=0: res<=ZDIV_RES, go to ACK.
    - otherwise go to ISSUE.
  - ISSUE: drive mul_start or div_start high for exactly one cycle, with registered args (mul: a[11:0], b; div: a, b). Go to WAIT.
  - WAIT: complete when the start register is 0 and the selected run is 0. Capture res (mul_res or div_res, 24 bits). Go to ACK. Run is not sampled in the cycle the start register is high.
  - ACK: done[g]=1. When req[g]=0: done<=0, grant<=0, advance RR pointer to g+1 mod NREQ, go to IDLE.
- Arbitration: round-robin starting at the RR pointer. The first asserted req at or after the pointer wins. Requests arriving during a transaction wait; nothing is queued beyond the req level.
- Latency:
  - Zero-divide: done is visible 2 edges after req is sampled in IDLE.
  - Normal: done is visible at engine latency + 3 edges.
- A single requester cannot starve others: after its ACK, priority passes to the next index.
- req high in the same cycle it drops elsewhere causes no conflict; only grant[g] is consulted in ACK.
- busy = (state != IDLE).

Optional Feature:
- Macro: VIDEO_ARITH_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest asserted index always wins, and the RR pointer logic is removed.
- Undefined: round-robin as above.
- Handshake, latency and zero-divide behaviour are identical in both builds.

Test Plan:
- req[0], op=0, a=400, b=2 -> done[0]=1, res=800; hold req 3 cycles -> done stays 1; drop req -> done=0 and busy=0 the next cycle.
- req[1], op=1, a=1080, b=480 -> res=2; then a=4096, b=3 -> res=1365.
- req[0] and req[1] asserted together with pointer=0, both re-requesting after each ACK -> grants ordered 0,1,0,1. With VIDEO_ARITH_ARB_FIXED_PRIO_EN defined -> 0,0,0 while req[0] persists.
- op=1, b=0, a=1920 -> res=24'hFFFFFF; done 2 edges after sampling; mul_start and div_start never pulse.
- reset asserted in WAIT -> done, grant, busy and res all 0 next cycle; a new request is not issued until div_run=0; the next result is correct.
- req[0] dropped in WAIT (illegal) -> done[0] pulses for one cycle, then IDLE; a pending req[1] is served next.

Source files
------------

// File: rtl/video_arith_arbiter.sv
// Shares one iterative 12x12 multiplier and one 24/12 divider between NREQ requesters.
// Build option: VIDEO_ARITH_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.

module sys_umul #(
  parameter int AW = 12,
  parameter int BW = 12
) (
  input  logic             clk,
  input  logic             start,
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  output logic             run,
  output logic [AW+BW-1:0] res
);
  localparam int CW = $clog2(BW + 1);

  logic [AW+BW-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [BW-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Shift-add, one multiplier bit per cycle; run is high while bits remain.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{BW{1'b0}}, a};
      mplier_d = b;
      cnt_d    = CW'(BW);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
    end
  end

  // No reset: a run in flight always drains on its own.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    cnt_q    <= cnt_d;
  end

  assign run = (cnt_q != '0);
  assign res = acc_q;
endmodule

module sys_udiv #(
  parameter int NW = 24,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          start,
  input  logic [NW-1:0] n,
  input  logic [DW-1:0] d,
  output logic          run,
  output logic [NW-1:0] res
);
  localparam int CW = $clog2(NW + 1);

  logic [NW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d, d_q, d_d;
  logic [DW:0]   rem_sh;
  logic [CW-1:0] cnt_q, cnt_d;

  // Restoring division, one quotient bit per cycle.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    rem_sh = {rem_q, quo_q[NW-1]};
    if (start) begin
      quo_d = n;
      rem_d = '0;
      d_d   = d;
      cnt_d = CW'(NW);
    end else if (cnt_q != '0) begin
      if (rem_sh >= {1'b0, d_q}) begin
        rem_d = DW'(rem_sh - {1'b0, d_q});
        quo_d = {quo_q[NW-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[DW-1:0];
        quo_d = {quo_q[NW-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    quo_q <= quo_d;
    rem_q <= rem_d;
    d_q   <= d_d;
    cnt_q <= cnt_d;
  end

  assign run = (cnt_q != '0);
  assign res = quo_q;
endmodule

module video_arith_arbiter #(
  parameter int          NREQ     = 2,
  parameter logic [23:0] ZDIV_RES = 24'hFFFFFF
) (
  input  logic              CLK_VIDEO,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   op,
  input  logic [NREQ*24-1:0] arg_a,
  input  logic [NREQ*12-1:0] arg_b,
  output logic [NREQ-1:0]   done,
  output logic [23:0]       res,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  // Handshake: req[i] is held with stable op/args until done[i]; done[i] holds until req[i] falls.
  state_t          state_q, state_d;
  logic [GW-1:0]   g_q, g_d, win_idx;
  logic            win_found;
  logic [NREQ-1:0] grant_q, grant_d, done_q, done_d;
  logic            op_q, op_d;
  logic [23:0]     a_q, a_d, res_q, res_d;
  logic [11:0]     b_q, b_d;
  logic            mul_start_q, mul_start_d, div_start_q, div_start_d;
  logic            mul_run, div_run;
  logic [23:0]     mul_res, div_res;
`ifndef VIDEO_ARITH_ARB_FIXED_PRIO_EN
  logic [GW-1:0]   ptr_q, ptr_d;
  int              idx;
`endif

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef VIDEO_ARITH_ARB_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        win_found = 1'b1;
        win_idx   = GW'(k);
      end
    end
`else
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req[GW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = GW'(idx);
      end
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    grant_d     = grant_q;
    done_d      = done_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    mul_start_d = 1'b0;
    div_start_d = 1'b0;
`ifndef VIDEO_ARITH_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found && !mul_run && !div_run) begin
          g_d          = win_idx;
          grant_d      = '0;
          grant_d[win_idx] = 1'b1;
          op_d         = op[win_idx];
          a_d          = arg_a[int'(win_idx)*24 +: 24];
          b_d          = arg_b[int'(win_idx)*12 +: 12];
          if (op[win_idx] && (arg_b[int'(win_idx)*12 +: 12] == 12'd0)) begin
            res_d   = ZDIV_RES;
            state_d = ACK;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (op_q) div_start_d = 1'b1;
        else      mul_start_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // Run only rises the edge after start, so ignore it while start is still high.
        if (!mul_start_q && !div_start_q && !(op_q ? div_run : mul_run)) begin
          res_d   = op_q ? div_res : mul_res;
          state_d = ACK;
        end
      end
      ACK: begin
        if (done_q == '0) begin
          done_d = grant_q;
        end else if (!req[g_q]) begin
          done_d  = '0;
          grant_d = '0;
`ifndef VIDEO_ARITH_ARB_FIXED_PRIO_EN
          ptr_d   = (g_q == GW'(NREQ - 1)) ? '0 : g_q + 1'b1;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      state_q     <= IDLE;
      g_q         <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      op_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
`ifndef VIDEO_ARITH_ARB_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
`ifndef VIDEO_ARITH_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  sys_umul #(.AW(12), .BW(12)) u_mul (
    .clk(CLK_VIDEO), .start(mul_start_q), .a(a_q[11:0]), .b(b_q),
    .run(mul_run), .res(mul_res)
  );

  sys_udiv #(.NW(24), .DW(12)) u_div (
    .clk(CLK_VIDEO), .start(div_start_q), .n(a_q), .d(b_q),
    .run(div_run), .res(div_res)
  );

  assign done  = done_q;
  assign res   = res_q;
  assign grant = grant_q;
  assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_video_arith_arbiter.sv
// Directed and randomized checks of video_arith_arbiter against a behavioural result/arbitration model.
module tb_video_arith_arbiter;
  localparam int NREQ = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req, op, done, grant;
  logic [NREQ*24-1:0]  arg_a;
  logic [NREQ*12-1:0]  arg_b;
  logic [23:0]         res;
  logic                busy;

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;
  int starts = 0;

  logic        t_op [NREQ];
  logic [23:0] t_a  [NREQ];
  logic [11:0] t_b  [NREQ];

  video_arith_arbiter #(.NREQ(NREQ), .ZDIV_RES(24'hFFFFFF)) dut (
    .CLK_VIDEO(clk), .reset(reset), .req(req), .op(op), .arg_a(arg_a),
    .arg_b(arg_b), .done(done), .res(res), .grant(grant), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.mul_start_q || dut.div_start_q) starts++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [23:0] ref_res(logic o, logic [23:0] a, logic [11:0] b);
    if (!o) return 24'(a[11:0]) * 24'(b);
    if (b == 12'd0) return 24'hFFFFFF;
    return a / 24'(b);
  endfunction

  function automatic int ref_winner(logic [NREQ-1:0] r, int p);
`ifdef VIDEO_ARITH_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks (called at a negedge)
  task automatic raise(int i, logic o, logic [23:0] a, logic [11:0] b);
    t_op[i] = o; t_a[i] = a; t_b[i] = b;
    op[i] = o;
    arg_a[24*i +: 24] = a;
    arg_b[12*i +: 12] = b;
    req[i] = 1'b1;
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int n = 0; n < 300; n++) begin
      if (grant != '0) break;
      @(negedge clk);
    end
    for (int i = 0; i < NREQ; i++) if (grant[i]) g = i;
    if (g < 0) chk("grant_timeout", 32'(grant), 32'(1));
  endtask

  task automatic wait_done(int i);
    for (int n = 0; n < 300; n++) begin
      if (done[i]) break;
      @(negedge clk);
    end
    chk("done_seen", 32'(done[i]), 32'(1));
  endtask

  task automatic finish_txn(int i);
    chk("res", 32'(res), 32'(ref_res(t_op[i], t_a[i], t_b[i])));
    chk("grant_owner", 32'(grant), 32'(1 << i));
    req[i] = 1'b0;
    @(negedge clk);
    chk("done_clear", 32'(done[i]), 32'(0));
    chk("busy_clear", 32'(busy), 32'(0));
    ptr_m = (i + 1) % NREQ;
  endtask

  task automatic do_txn(int i, logic o, logic [23:0] a, logic [11:0] b);
    int g;
    raise(i, o, a, b);
    wait_grant(g);
    chk("winner", 32'(g), 32'(i));
    wait_done(i);
    finish_txn(i);
  endtask

  initial begin
    int g, e, s0, pulses;
    reset = 1'b1; req = '0; op = '0; arg_a = '0; arg_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_res", 32'(res), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // multiply with held done
    raise(0, 1'b0, 24'd400, 12'd2);
    wait_grant(g);
    wait_done(0);
    chk("mul_400x2", 32'(res), 32'd800);
    repeat (3) begin
      @(negedge clk);
      chk("hold_done", 32'(done[0]), 32'(1));
    end
    finish_txn(0);

    // divides
    do_txn(1, 1'b1, 24'd1080, 12'd480);
    do_txn(1, 1'b1, 24'd4096, 12'd3);

    // contention, both re-requesting after each ACK
    raise(0, 1'b0, 24'($urandom_range(0, 24'hFFFFFF)), 12'($urandom_range(0, 4095)));
    raise(1, 1'b1, 24'($urandom_range(0, 24'hFFFFFF)), 12'($urandom_range(1, 4095)));
    for (int it = 0; it < 6 && req != '0; it++) begin
      e = ref_winner(req, ptr_m);
      wait_grant(g);
      chk("rr_grant", 32'(g), 32'(e));
      if (g < 0) break;
      wait_done(g);
      finish_txn(g);
      if (it < 3)
        raise(g, 1'($urandom_range(0, 1)), 24'($urandom_range(0, 24'hFFFFFF)),
              12'($urandom_range(1, 4095)));
    end

    // divide by zero
    s0 = starts;
    raise(0, 1'b1, 24'd1920, 12'd0);
    @(negedge clk);
    chk("zdiv_early", 32'(done[0]), 32'(0));
    @(negedge clk);
    chk("zdiv_lat", 32'(done[0]), 32'(1));
    chk("zdiv_res", 32'(res), 32'hFFFFFF);
    finish_txn(0);
    chk("zdiv_nostart", 32'(starts), 32'(s0));

    // random single transactions
    for (int t = 0; t < 16; t++) begin
      logic [11:0] rb;
      rb = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
      do_txn(int'($urandom_range(0, NREQ - 1)), 1'($urandom_range(0, 1)),
             24'($urandom), rb);
    end

    // reset during WAIT
    raise(0, 1'b1, 24'hABCDEF, 12'h013);
    wait_grant(g);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    chk("wrst_done", 32'(done), 32'(0));
    chk("wrst_grant", 32'(grant), 32'(0));
    chk("wrst_busy", 32'(busy), 32'(0));
    chk("wrst_res", 32'(res), 32'(0));
    chk("wrst_run_kept", 32'(dut.div_run), 32'(1));
    reset = 1'b0;
    ptr_m = 0;
    raise(0, 1'b1, 24'd1000000, 12'd7);
    for (int n = 0; n < 100 && dut.div_run; n++) begin
      chk("wrst_no_issue", 32'(busy), 32'(0));
      @(negedge clk);
    end
    wait_grant(g);
    wait_done(0);
    chk("wrst_next_res", 32'(res), 32'd142857);
    finish_txn(0);

    // illegal early drop with a pending requester
    raise(0, 1'b1, 24'($urandom), 12'($urandom_range(1, 4095)));
    wait_grant(g);
    chk("drop_owner", 32'(g), 32'(0));
    raise(1, 1'b0, 24'($urandom), 12'($urandom));
    repeat (3) @(negedge clk);
    req[0] = 1'b0;
    pulses = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done[0]) begin
        pulses++;
        chk("drop_res", 32'(res), 32'(ref_res(t_op[0], t_a[0], t_b[0])));
      end
      if (grant == 2'b10) break;
    end
    chk("drop_pulse", 32'(pulses), 32'(1));
    wait_done(1);
    finish_txn(1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
